// File: rtl/sram_controller.sv
// Bridges single-cycle 32-bit pipeline loads/stores onto a 16-bit asynchronous SRAM.
// Each word is moved as two halfword accesses, so every access has a fixed six-cycle turnaround.
module sram_controller #(
   parameter int          N         = 32,
   parameter logic [31:0] BASE_ADDR = 32'd1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic         rd_en,
   input  logic [N-1:0] address,
   input  logic [N-1:0] writeData,
   output logic [N-1:0] readData,
   output logic         ready,
   inout  wire  [15:0]  SRAM_DQ,
   output logic [17:0]  SRAM_ADDR,
   output logic         SRAM_WE_N,
   output logic         SRAM_OE_N,
   output logic         SRAM_CE_N,
   output logic         SRAM_UB_N,
   output logic         SRAM_LB_N
);

   typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT1, WAIT2, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  addr_q;
   logic [N-1:0]  wdata_q;
   logic          write_q;
   logic [N-1:0]  rdata_q;
   logic          request;
   logic          accept;
   logic [31:0]   offset;
   logic          dqDrive;
   logic [15:0]   dqOut;
   logic          unusedOffsetBits;

   assign request = wr_en | rd_en;
   assign accept  = (state_q == IDLE) && request;

   // Word offset into the SRAM; the byte lane and bits beyond the 256K-halfword space are dropped.
   assign offset           = addr_q - BASE_ADDR;
   assign unusedOffsetBits = ^{offset[31:19], offset[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (request) state_d = ACC_LO;
         ACC_LO:  state_d = ACC_HI;
         ACC_HI:  state_d = WAIT1;
         WAIT1:   state_d = WAIT2;
         WAIT2:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The request is captured once at acceptance so the pipeline may change its inputs mid-access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= address;
            wdata_q <= writeData;
            write_q <= wr_en;
         end
         if ((state_q == ACC_LO) && !write_q) begin
            rdata_q[15:0] <= SRAM_DQ;
         end
         if ((state_q == ACC_HI) && !write_q) begin
            rdata_q[31:16] <= SRAM_DQ;
         end
      end
   end

   always_comb begin
      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dqDrive   = 1'b0;
      dqOut     = '0;
      case (state_q)
         ACC_LO: begin
            SRAM_ADDR = {offset[18:2], 1'b0};
            if (write_q) begin
               SRAM_WE_N = 1'b0;
               dqDrive   = 1'b1;
               dqOut     = wdata_q[15:0];
            end else begin
               SRAM_OE_N = 1'b0;
            end
         end
         ACC_HI: begin
            SRAM_ADDR = {offset[18:2], 1'b1};
            if (write_q) begin
               SRAM_WE_N = 1'b0;
               dqDrive   = 1'b1;
               dqOut     = wdata_q[31:16];
            end else begin
               SRAM_OE_N = 1'b0;
            end
         end
         default: ;
      endcase
      ready = !(accept || (state_q == ACC_LO) || (state_q == ACC_HI) ||
                (state_q == WAIT1) || (state_q == WAIT2));
   end

   assign SRAM_DQ   = dqDrive ? dqOut : 16'hzzzz;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign readData  = rdata_q;

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter N, default 32, meaning pipeline-side data width (only N=32 supported).
REQ-002 SHALL have parameter BASE_ADDR, default 1024, meaning byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1, meaning pipeline store request.
REQ-006 SHALL have port rd_en, input, 1, meaning pipeline load request.
REQ-007 SHALL have port address, input, N, meaning byte address of the access (ALU result).
REQ-008 SHALL have port writeData, input, N, meaning store data (Rm value).
REQ-009 SHALL have port readData, output, N, meaning load result.
REQ-010 SHALL have port ready, output, 1, meaning access complete; pipeline freezes while 0.
REQ-011 SHALL have ports SRAM_DQ, inout, 16, SRAM data bus; SRAM_ADDR, output, 18, SRAM halfword address.
REQ-012 SHALL have ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, outputs, 1 each, active-low SRAM strobes.

Function
REQ-013 SHALL implement FSM states IDLE, ACC_LO, ACC_HI, WAIT1, WAIT2, DONE.
REQ-014 SHALL, in IDLE, accept a request when wr_en|rd_en=1; next state ACC_LO; otherwise stay IDLE.
REQ-015 SHALL, on acceptance, latch address, writeData, and op (write if wr_en=1, else read); wr_en has priority when both are asserted.
REQ-016 SHALL sequence ACC_LO -> ACC_HI -> WAIT1 -> WAIT2 -> DONE -> IDLE unconditionally, one state per cycle.
REQ-017 SHALL complete an accepted transaction even if wr_en/rd_en/address change or drop mid-transaction.
REQ-018 SHALL compute offset = latched address - BASE_ADDR (32-bit wrap); SRAM_ADDR = {offset[18:2],0} in ACC_LO and {offset[18:2],1} in ACC_HI; offset[1:0] ignored.
REQ-019 SHALL drive SRAM_ADDR=0 in all other states.
REQ-020 SHALL, on a write, drive SRAM_WE_N=0 with SRAM_DQ=writeData[15:0] in ACC_LO and writeData[31:16] in ACC_HI.
REQ-021 SHALL hold SRAM_DQ high-impedance and SRAM_WE_N=1 in all other states and on every read.
REQ-022 SHALL, on a read, drive SRAM_OE_N=0 in ACC_LO and ACC_HI; sample SRAM_DQ into readData[15:0] at the end of ACC_LO and readData[31:16] at the end of ACC_HI.
REQ-023 SHALL hold SRAM_OE_N=1 otherwise; SRAM_CE_N, SRAM_UB_N, SRAM_LB_N SHALL be constant 0.
REQ-024 SHALL hold readData stable between reads; writes SHALL not alter readData.
REQ-025 SHALL drive ready combinationally: 0 when state is IDLE with wr_en|rd_en=1, or state is ACC_LO..WAIT2; 1 in IDLE with no request and in DONE.
REQ-026 SHALL yield fixed latency: request at cycle 0, ready=0 for cycles 0-4, ready=1 at cycle 5; a request still asserted in DONE SHALL not start a new access.
REQ-027 SHALL accept a new request in the IDLE cycle immediately after DONE (back-to-back accesses every 6 cycles).

Reset
REQ-028 SHALL, on rst=1, immediately enter IDLE, drive readData=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, and SRAM_DQ high-Z, aborting any transaction in progress; ready then follows REQ-025.
REQ-029 SHALL, on rst release, stay in IDLE until the next rising clk edge with a request.

Verification
REQ-030 Bench SHALL cover: write address=1024, writeData=32'hDEADBEEF -> SRAM_ADDR=0 with DQ=16'hBEEF, then SRAM_ADDR=1 with DQ=16'hDEAD, WE_N low both cycles; ready low 5 cycles, then high 1 cycle.
REQ-031 Bench SHALL cover: read address=1024 after REQ-030 using an SRAM model -> readData=32'hDEADBEEF at DONE; ready pattern matches REQ-026.
REQ-032 Bench SHALL cover: write address=1032 (offset 8), writeData=32'h12345678 -> SRAM_ADDR=4 then 5; readback from 1032 gives 32'h12345678 and readback from 1024 still gives 32'hDEADBEEF.
REQ-033 Bench SHALL cover: rd_en=wr_en=1 at address 1028, writeData=32'hA5A5_5A5A -> write performed, readData unchanged, later read returns 32'hA5A55A5A.
REQ-034 Bench SHALL cover: rst asserted during ACC_HI of a write -> same-cycle WE_N=1, DQ high-Z, readData=0, state IDLE; ready=1 once requests are deasserted.
REQ-035 Bench SHALL cover: rd_en dropped after cycle 1 -> transaction still completes, DONE reached at cycle 5, readData updated.
